elevator_ctrl: RTL

Parametrised elevator controller: the next generation of the project's 4-floor `state_machine`. It generalises floor count and travel timing, and adds several behaviours: latched multi-floor call requests, SCAN (keep-direction) scheduling, a timed door phase, and a freeze input. It sits between the request inputs (buttons) and the floor display/motor logic. All behaviour is synchronous to one clock.

---
 rtl/elevator_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: parametrised SCAN elevator controller with latched call
// requests, a timed door phase and a freeze input.
module elevator_ctrl #(
  parameter int FLOORS      = 8,
  parameter int FLOOR_W     = 3,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               stop_go,
  input  logic               req_valid,
  input  logic [FLOOR_W-1:0] req_floor,
  output logic [FLOOR_W-1:0] output_floor,
  output logic               dir,
  output logic               moving,
  output logic               door_open,
  output logic [FLOORS-1:0]  pending
);

  localparam int CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]   MOVE_LAST = CNT_W'(MOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DOOR_LAST = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [FLOOR_W-1:0] FLOOR_ONE = FLOOR_W'(1);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_e;

  state_e             state_q, state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FLOORS-1:0]  pending_q, pending_d;
  logic               moving_q, moving_d;
  logic               door_q, door_d;

  logic [FLOOR_W-1:0] step_floor;
  logic [FLOORS-1:0]  set_vec, here_vec, step_vec;
  logic               req_here, hit_here, hit_step;
  logic               any_above, any_below, ahead, behind;

  // Decode of the registered state against the request bitmap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    step_floor = dir_q ? floor_q + FLOOR_ONE : floor_q - FLOOR_ONE;
    set_vec    = '0;
    here_vec   = '0;
    step_vec   = '0;
    any_above  = 1'b0;
    any_below  = 1'b0;
    for (int f = 0; f < FLOORS; f++) begin
      if (req_valid && (req_floor == FLOOR_W'(f))) set_vec[f] = 1'b1;
      if (floor_q == FLOOR_W'(f))                  here_vec[f] = 1'b1;
      if (step_floor == FLOOR_W'(f))               step_vec[f] = 1'b1;
      if (pending_q[f] && (f > int'(floor_q)))     any_above = 1'b1;
      if (pending_q[f] && (f < int'(floor_q)))     any_below = 1'b1;
    end
    req_here = req_valid && (req_floor == floor_q);
    hit_here = |(pending_q & here_vec);
    hit_step = |(pending_q & step_vec);
    ahead    = dir_q ? any_above : any_below;
    behind   = dir_q ? any_below : any_above;
  end

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    // A call for the floor whose door is open only extends the door phase.
    pending_d = (state_q == DOOR) ? (pending_q | (set_vec & ~here_vec))
                                  : (pending_q | set_vec);
    if (!stop_go) begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (hit_here) begin
            pending_d = pending_d & ~here_vec;
            state_d   = DOOR;
          end else if (any_above) begin
            state_d = MOVE;
            dir_d   = 1'b1;
          end else if (any_below) begin
            state_d = MOVE;
            dir_d   = 1'b0;
          end
        end
        MOVE: begin
          if (cnt_q == MOVE_LAST) begin
            floor_d = step_floor;
            cnt_d   = '0;
            if (hit_step) begin
              pending_d = pending_d & ~step_vec;
              state_d   = DOOR;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        DOOR: begin
          if (req_here) begin
            cnt_d = '0;
          end else if (cnt_q == DOOR_LAST) begin
            cnt_d = '0;
            if (ahead) begin
              state_d = MOVE;
            end else if (behind) begin
              state_d = MOVE;
              dir_d   = ~dir_q;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    moving_d = (state_d == MOVE);
    door_d   = (state_d == DOOR);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      dir_q     <= 1'b1;
      cnt_q     <= '0;
      pending_q <= '0;
      moving_q  <= 1'b0;
      door_q    <= 1'b0;
    end else begin
      // NOTE: state updates use <= so every flop samples the same pre-edge values.
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      moving_q  <= moving_d;
      door_q    <= door_d;
    end
  end

  assign output_floor = floor_q;
  assign dir          = dir_q;
  assign moving       = moving_q;
  assign door_open    = door_q;
  assign pending      = pending_q;

endmodule
